mult16_shift_add: RTL and testbench



---
 rtl/mult16_shift_add.sv | 90 +++++++++
 tb/tb_mult16_shift_add.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult16_shift_add.sv
// Unsigned shift-and-add multiplier: WIDTH RUN cycles per product (fewer if MULT_EARLY_TERM_EN is defined).
// start is taken only in IDLE or DONE and ignored while busy; done pulses for one cycle as p/ovfl update.
module mult16_shift_add #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] p,
   output logic             ovfl
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   mplier_nxt;
   logic [CW-1:0]      count;
   logic               last;

   always_comb begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mplier_nxt = mplier >> 1;
`ifdef MULT_EARLY_TERM_EN
      // no set bits left in the multiplier means the remaining steps add nothing
      last       = (count == CW'(WIDTH-1)) || (mplier_nxt == '0);
`else
      last       = (count == CW'(WIDTH-1));
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         p      <= '0;
         ovfl   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, a};
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier_nxt;
               count  <= count + 1'b1;
               if (last) begin
                  p     <= acc_nxt[WIDTH-1:0];
                  ovfl  <= |acc_nxt[2*WIDTH-1:WIDTH];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult16_shift_add.sv
// Scoreboard bench for mult16_shift_add: expected product, overflow and latency queued per accepted start.
module tb_mult16_shift_add;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] p;
   logic        ovfl;

   mult16_shift_add #(.WIDTH(16)) dut (
      .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .p(p), .ovfl(ovfl)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] p;
      logic        ovfl;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   busy_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_lat(input logic [15:0] bv);
`ifdef MULT_EARLY_TERM_EN
      int n = 1;
      for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
      return n;
`else
      return 16;
`endif
   endfunction

   // drive on the current negedge; the following posedge accepts
   task automatic drive(input logic [15:0] av, input logic [15:0] bv);
      exp_t        e;
      logic [31:0] full;
      full      = {16'h0, av} * {16'h0, bv};
      e.p       = full[15:0];
      e.ovfl    = |full[31:16];
      e.lat     = exp_lat(bv);
      e.acc_cyc = cyc + 1;
      a = av; b = bv; start = 1'b1;
      sbq.push_back(e);
      @(negedge clock);
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
   endtask

   task automatic issue(input logic [15:0] av, input logic [15:0] bv);
      @(negedge clock);
      drive(av, bv);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (sbq.size() != 0 && k < budget) begin
         @(negedge clock);
         k++;
      end
      if (sbq.size() != 0) begin
         chk("timeout", 64'(sbq.size()), 0);
         sbq.delete();
      end
      @(negedge clock);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (busy && done) chk("busy_done_excl", 1, 0);
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("p", p, e.p);
               chk("ovfl", ovfl, e.ovfl);
               chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
               chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin
      int k;
      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_p", p, 0);
      chk("rst_ovfl", ovfl, 0);
      reset = 1'b0;

      // basic product and result hold through idle
      issue(16'd3, 16'd5);
      wait_idle(40);
      chk("t1_p", p, 16'd15);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("t1_hold_p", p, 16'd15);
         chk("t1_idle_busy", busy, 0);
      end

      issue(16'h0100, 16'h0100);
      wait_idle(40);
      issue(16'hFFFF, 16'h0001);
      wait_idle(40);

      // start during RUN ignored, then back-to-back start in the done cycle
      issue(16'd7, 16'd9);
      repeat (4) @(negedge clock);
      a = 16'd1; b = 16'd1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!done && k < 40);
      if (!done) chk("t3_done_seen", 0, 1);
      chk("t3_p63", p, 16'd63);
      drive(16'd2, 16'd4);
      wait_idle(40);
      chk("t3_p8", p, 16'd8);

      // reset in the middle of RUN clears everything before the next edge
      issue(16'd100, 16'd200);
      repeat (7) @(negedge clock);
      chk("t4_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_done", done, 0);
      chk("t4_rst_p", p, 0);
      chk("t4_rst_ovfl", ovfl, 0);
      sbq.delete();
      @(negedge clock);
      reset = 1'b0;
      issue(16'd100, 16'd200);
      wait_idle(40);
      chk("t4_p", p, 16'd20000);

      issue(16'h0000, 16'hFFFF);
      wait_idle(40);
      issue(16'hFFFF, 16'hFFFF);
      wait_idle(40);
      chk("t5_p", p, 16'h0001);
      chk("t5_ovfl", ovfl, 1);

      // data-dependent latency cases (fixed 16 cycles unless early termination is built in)
      issue(16'd5, 16'h0000);
      wait_idle(40);
      issue(16'd7, 16'h0001);
      wait_idle(40);
      issue(16'd3, 16'h0080);
      wait_idle(40);
      chk("t6_p384", p, 16'd384);
      issue(16'd9, 16'h8000);
      wait_idle(40);

      for (int i = 0; i < 6; i++) begin
         issue(16'($urandom), 16'($urandom));
         wait_idle(40);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
